// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : fetch_unit
// Purpose  : RV32I instruction-fetch front end. It contains a PC sequencer, a
//            valid/ready interface to a variable-latency instruction memory,
//            and an in-order prefetch FIFO that feeds decode.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fetch_unit #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              misalign_err
);

  localparam int                c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int                c_CNT_W   = c_PTR_W + 1;
  localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);
  localparam logic [c_CNT_W:0]  c_CREDITS = (c_CNT_W + 1)'(FIFO_DEPTH);

  logic                r_run;
  logic [ADDR_W-1:0]   r_fetchPc;
  logic [ADDR_W-1:0]   r_rspPc;
  logic [c_CNT_W-1:0]  r_outstanding;
  logic [c_CNT_W-1:0]  r_drop;
  logic [c_CNT_W-1:0]  r_count;
  logic [c_PTR_W-1:0]  r_wrPtr;
  logic [c_PTR_W-1:0]  r_rdPtr;
  logic                r_misalign;
  logic [31:0]         r_fifoData [FIFO_DEPTH];
  logic [ADDR_W-1:0]   r_fifoPc   [FIFO_DEPTH];

  logic [c_CNT_W:0]    w_used;
  logic                w_reqValid;
  logic                w_reqFire;
  logic                w_rspTake;
  logic                w_push;
  logic                w_pop;
  logic [ADDR_W-1:0]   w_redirPc;

  // Credits cover both in-flight and buffered fetches, so a push never overflows.
  assign w_used     = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_reqValid = r_run && !redirect_valid && (w_used < c_CREDITS);
  assign w_reqFire  = w_reqValid && imem_req_ready;
  assign w_rspTake  = imem_rsp_valid && (r_outstanding != '0);
  assign w_push     = w_rspTake && (r_drop == '0) && !redirect_valid;
  assign w_pop      = (r_count != '0) && inst_ready && !redirect_valid;
  assign w_redirPc  = {redirect_addr[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run         <= 1'b0;
      r_fetchPc     <= RESET_VECTOR;
      r_rspPc       <= RESET_VECTOR;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_count       <= '0;
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_misalign    <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_misalign    <= redirect_valid && (redirect_addr[1:0] != 2'b00);
      r_outstanding <= r_outstanding + c_CNT_W'(w_reqFire) - c_CNT_W'(w_rspTake);
      if (redirect_valid) begin
        r_fetchPc <= w_redirPc;
        r_rspPc   <= w_redirPc;
        // drop is a subset of outstanding: every request still in flight is now stale.
        r_drop    <= r_outstanding - c_CNT_W'(w_rspTake);
        r_count   <= '0;
        r_wrPtr   <= '0;
        r_rdPtr   <= '0;
      end else begin
        if (w_reqFire) begin
          r_fetchPc <= r_fetchPc + c_PC_STEP;
        end
        if (w_push) begin
          r_rspPc <= r_rspPc + c_PC_STEP;
          r_wrPtr <= r_wrPtr + c_PTR_W'(1);
        end
        if (w_rspTake && (r_drop != '0)) begin
          r_drop <= r_drop - c_CNT_W'(1);
        end
        if (w_pop) begin
          r_rdPtr <= r_rdPtr + c_PTR_W'(1);
        end
        r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifoData[i] <= '0;
        r_fifoPc[i]   <= '0;
      end
    end else if (w_push) begin
      r_fifoData[r_wrPtr] <= imem_rsp_data;
      r_fifoPc[r_wrPtr]   <= r_rspPc;
    end
  end

  assign imem_req_valid = w_reqValid;
  assign imem_req_addr  = r_fetchPc;
  assign inst_valid     = (r_count != '0);
  assign inst_data      = r_fifoData[r_rdPtr];
  assign inst_pc        = r_fifoPc[r_rdPtr];
  assign misalign_err   = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit with a scoreboard of expected
//            instructions and an in-order variable-latency memory model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_unit;

  localparam int c_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        misalign_err;

  logic        reqValid16;
  logic [15:0] reqAddr16;
  logic        rspValid16;
  logic [31:0] rspData16;
  logic        redirValid16;
  logic        instValid16;
  logic [31:0] instData16;
  logic [15:0] instPc16;
  logic        misalign16;

  fetch_unit #(.ADDR_W(32), .RESET_VECTOR(32'h0), .FIFO_DEPTH(c_DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .misalign_err   (misalign_err)
  );

  fetch_unit #(.ADDR_W(16), .RESET_VECTOR(16'h0), .FIFO_DEPTH(4)) dut16 (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (reqValid16),
    .imem_req_ready (1'b1),
    .imem_req_addr  (reqAddr16),
    .imem_rsp_valid (rspValid16),
    .imem_rsp_data  (rspData16),
    .redirect_valid (redirValid16),
    .redirect_addr  (16'hFFFC),
    .inst_valid     (instValid16),
    .inst_ready     (1'b1),
    .inst_data      (instData16),
    .inst_pc        (instPc16),
    .misalign_err   (misalign16)
  );

  int          nChecks = 0;
  int          nErrors = 0;
  int          cyc = 0;
  int          relCyc = 0;
  int          lat = 1;
  int          nFires = 0;
  int          nMis = 0;
  int          firstReqCyc = -1;
  int          firstInstCyc = -1;
  logic [31:0] expPc = '0;
  logic        expMis = 1'b0;
  logic        popMark = 1'b0;
  logic [31:0] firstPop = '0;

  logic        stRedir = 1'b0;
  logic [31:0] stRedirAddr = '0;
  logic        stInstRdy = 1'b1;
  logic        stReqRdy = 1'b1;
  logic        stRed16 = 1'b0;
  logic        log16 = 1'b0;

  exp_t        sb[$];
  pend_t       pend[$];
  logic [15:0] q16Req[$];
  logic [15:0] q16Pc[$];
  logic [31:0] q16Data[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs and memory response on the falling edge, then sample.
  task automatic step();
    pend_t ret;
    logic  retV;
    logic  expReq;
    exp_t  e;
    @(negedge clk);
    cyc++;
    redirect_valid = stRedir;
    redirect_addr  = stRedirAddr;
    inst_ready     = stInstRdy;
    imem_req_ready = stReqRdy;
    retV           = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
      ret            = pend.pop_front();
      retV           = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memData(ret.addr);
    end
    #1;
    if (rst_n) begin
      checkVal("misalign_err", misalign_err, expMis);
      expMis = 1'b0;
      if (misalign_err) nMis++;
      checkVal("inst_valid", inst_valid, sb.size() != 0);
      expReq = !redirect_valid && ((pend.size() + int'(retV) + sb.size()) < c_DEPTH);
      checkVal("req_valid", imem_req_valid, expReq);
      if (!redirect_valid && inst_valid && inst_ready && sb.size() != 0) begin
        e = sb.pop_front();
        checkVal("inst_pc", inst_pc, e.pc);
        checkVal("inst_data", inst_data, e.data);
        if (popMark) begin
          firstPop = inst_pc;
          popMark  = 1'b0;
        end
      end
      if (inst_valid && firstInstCyc < 0) firstInstCyc = cyc - relCyc;
      if (redirect_valid) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        if (retV) ret.stale = 1'b1;
        sb.delete();
        expPc   = {redirect_addr[31:2], 2'b00};
        expMis  = (redirect_addr[1:0] != 2'b00);
        popMark = 1'b1;
      end else if (imem_req_valid && imem_req_ready) begin
        checkVal("req_addr", imem_req_addr, expPc);
        pend.push_back('{expPc, cyc + lat, 1'b0});
        expPc = expPc + 32'd4;
        nFires++;
        if (firstReqCyc < 0) firstReqCyc = cyc - relCyc;
      end
      if (retV && !ret.stale) sb.push_back('{ret.addr, memData(ret.addr)});
    end
  endtask

  task automatic doRelease();
    rst_n        = 1'b1;
    relCyc       = cyc;
    firstReqCyc  = -1;
    firstInstCyc = -1;
    nFires       = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkVal("rst_inst_valid", inst_valid, 1'b0);
    checkVal("rst_req_valid", imem_req_valid, 1'b0);
    pend.delete();
    sb.delete();
    expPc          = '0;
    expMis         = 1'b0;
    imem_rsp_valid = 1'b0;
    step();
    step();
    doRelease();
  endtask

  // Second instance: 16-bit address space, 1-cycle memory, decode always ready.
  initial begin
    logic        p16V;
    logic [15:0] p16A;
    p16V         = 1'b0;
    p16A         = '0;
    rspValid16   = 1'b0;
    rspData16    = '0;
    redirValid16 = 1'b0;
    forever begin
      @(negedge clk);
      rspValid16   = p16V;
      rspData16    = memData({16'h0, p16A});
      redirValid16 = stRed16;
      if (stRed16) begin
        stRed16 = 1'b0;
        log16   = 1'b1;
      end
      #1;
      p16V = rst_n && reqValid16;
      p16A = reqAddr16;
      if (log16 && !redirValid16) begin
        if (reqValid16) q16Req.push_back(reqAddr16);
        if (instValid16) begin
          q16Pc.push_back(instPc16);
          q16Data.push_back(instData16);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d", nChecks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp16 [3];
    int          m0;
    exp16          = '{16'hFFFC, 16'h0000, 16'h0004};
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    repeat (3) step();
    checkVal("reset_req_valid", imem_req_valid, 1'b0);
    checkVal("reset_inst_valid", inst_valid, 1'b0);
    checkVal("reset_misalign", misalign_err, 1'b0);
    checkVal("reset_inst_data", inst_data, 32'h0);
    checkVal("reset_inst_pc", inst_pc, 32'h0);
    checkVal("reset_req_valid16", reqValid16, 1'b0);
    doRelease();

    // Streaming with a 1-cycle memory
    repeat (12) step();
    checkVal("first_req_latency", firstReqCyc, 1);
    checkVal("first_inst_latency", firstInstCyc, 3);

    // Fill the FIFO, then reset mid-stream
    stInstRdy = 1'b0;
    repeat (10) step();
    doReset();

    // Decode stall: credits run out after FIFO_DEPTH requests
    repeat (20) step();
    checkVal("stall_fires", nFires, 4);
    checkVal("stall_req_valid", imem_req_valid, 1'b0);
    stInstRdy = 1'b1;
    repeat (12) step();

    // Redirect with two responses in flight and one buffered
    doReset();
    stInstRdy = 1'b0;
    lat       = 1;
    step();
    lat = 3;
    step();
    step();
    stRedir     = 1'b1;
    stRedirAddr = 32'h100;
    step();
    stRedir   = 1'b0;
    stInstRdy = 1'b1;
    repeat (14) step();
    checkVal("first_pc_after_redirect", firstPop, 32'h100);

    // Misaligned redirect target
    lat = 1;
    repeat (6) step();
    m0          = nMis;
    stRedir     = 1'b1;
    stRedirAddr = 32'h203;
    step();
    stRedir = 1'b0;
    repeat (10) step();
    checkVal("misalign_pulses", nMis - m0, 1);
    checkVal("first_pc_after_misalign", firstPop, 32'h200);

    // Back-to-back redirects with slow memory
    lat = 3;
    repeat (6) step();
    stRedir     = 1'b1;
    stRedirAddr = 32'h400;
    step();
    stRedirAddr = 32'h500;
    step();
    stRedir = 1'b0;
    repeat (15) step();
    checkVal("first_pc_after_b2b", firstPop, 32'h500);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      lat         = int'($urandom_range(1, 3));
      stReqRdy    = ($urandom % 4) != 0;
      stInstRdy   = ($urandom % 3) != 0;
      stRedir     = ($urandom % 20) == 0;
      stRedirAddr = $urandom & 32'h0000_FFFF;
      step();
    end
    stRedir   = 1'b0;
    stReqRdy  = 1'b1;
    stInstRdy = 1'b1;
    lat       = 1;
    repeat (20) step();

    // 16-bit instance: wrap at the top of the address space
    stRed16 = 1'b1;
    repeat (10) step();
    checkVal("w16_req_count", q16Req.size() >= 3, 1'b1);
    checkVal("w16_pop_count", q16Pc.size() >= 3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i < q16Req.size()) checkVal("w16_req_addr", q16Req[i], exp16[i]);
      if (i < q16Pc.size()) begin
        checkVal("w16_inst_pc", q16Pc[i], exp16[i]);
        checkVal("w16_inst_data", q16Data[i], memData({16'h0, exp16[i]}));
      end
    end
    checkVal("w16_misalign", misalign16, 1'b0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

`default_nettype wire
